core_lsu: RTL and testbench

- Load/store unit downstream of the integer ALU.
- Takes the effective address the ALU produced for LB/LH/LW/LBU/LHU/SB/SH/SW, plus the RS2 store data.
- Runs one aligned word transaction on the data-memory port with a request/grant + response-valid handshake, then returns sign/zero-extended load data with a one-cycle DONE pulse.
- Detects misalignment and bus timeout; one access in flight at a time.

---
 rtl/core_lsu_pkg.sv | 25 ++
 rtl/core_lsu_align.sv | 43 ++++
 rtl/core_lsu.sv | 180 ++++++++++++++++++
 tb/tb_core_lsu.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_lsu_pkg.sv
// Shared constants and types for the load/store unit: FSM state codes, access
// sizes and the latched operation descriptor.
package core_lsu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef struct packed {
        logic [1:0] size;
        logic       sext;
        logic       store;
    } lsu_op_t;

    // Width of the bus-timeout counter; never below one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane steering: store byte enables and replicated data, misalignment
// detection, and extraction/extension of load data from the bus word.
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = mem_word >> {offset, 3'b000};
        be        = 4'b1111;
        lane_data = store_data;
        misalign  = 1'b0;
        load_data = shifted;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << offset;
                lane_data = {4{store_data[7:0]}};
                load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                be        = 4'b0011 << offset;
                lane_data = {2{store_data[15:0]}};
                misalign  = offset[0];
                load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                misalign  = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: accepts one access at a time, runs a single aligned word
// transaction on the data-memory port and reports completion with DONE.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        I_LB,
    input  logic        I_LH,
    input  logic        I_LW,
    input  logic        I_LBU,
    input  logic        I_LHU,
    input  logic        I_SB,
    input  logic        I_SH,
    input  logic        I_SW,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RDATA,
    output logic        MISALIGN,
    output logic        ERR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_GNT,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA
);

    localparam int             CW       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    lsu_op_t       op;
    lsu_op_t       in_op;
    lsu_op_t       a_op;
    logic [1:0]    op_off;
    logic [1:0]    a_off;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          op_valid;
    logic          pend_misalign;
    logic          pend_err;
    logic [3:0]    a_be;
    logic [31:0]   a_lane;
    logic          a_misalign;
    logic [31:0]   a_load;

    always_comb begin
        op_valid    = $onehot({I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW});
        in_op.size  = SZ_W;
        in_op.sext  = I_LB | I_LH;
        in_op.store = I_SB | I_SH | I_SW;
        if (I_LB | I_LBU | I_SB) begin
            in_op.size = SZ_B;
        end else if (I_LH | I_LHU | I_SH) begin
            in_op.size = SZ_H;
        end
    end

    // The aligner sees the incoming op while idle and the latched op afterwards,
    // so a single instance serves both store steering and load extraction.
    assign a_op     = (state == ST_IDLE) ? in_op : op;
    assign a_off    = (state == ST_IDLE) ? ADDR[1:0] : op_off;
    assign cnt_next = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;

    core_lsu_align u_align (
        .size       (a_op.size),
        .sext       (a_op.sext),
        .offset     (a_off),
        .store_data (WDATA),
        .mem_word   (MEM_RDATA),
        .be         (a_be),
        .lane_data  (a_lane),
        .misalign   (a_misalign),
        .load_data  (a_load)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            op            <= '0;
            op_off        <= '0;
            cnt           <= '0;
            pend_misalign <= 1'b0;
            pend_err      <= 1'b0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            RDATA         <= '0;
            MISALIGN      <= 1'b0;
            ERR           <= 1'b0;
            MEM_REQ       <= 1'b0;
            MEM_WE        <= 1'b0;
            MEM_ADDR      <= '0;
            MEM_BE        <= '0;
            MEM_WDATA     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        BUSY   <= 1'b1;
                        op     <= in_op;
                        op_off <= ADDR[1:0];
                        if (!op_valid) begin
                            pend_err <= 1'b1;
                            state    <= ST_FIN;
                        end else if (a_misalign) begin
                            pend_misalign <= 1'b1;
                            state         <= ST_FIN;
                        end else begin
                            MEM_REQ   <= 1'b1;
                            MEM_WE    <= in_op.store;
                            MEM_ADDR  <= {ADDR[31:2], 2'b00};
                            MEM_BE    <= a_be;
                            MEM_WDATA <= a_lane;
                            cnt       <= '0;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt_next;
                    if (MEM_GNT) begin
                        MEM_REQ <= 1'b0;
                        if (op.store) begin
                            DONE  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_RESP;
                        end
                    end else if (cnt == CNT_LAST) begin
                        MEM_REQ <= 1'b0;
                        RDATA   <= '0;
                        ERR     <= 1'b1;
                        DONE    <= 1'b1;
                        state   <= ST_FIN;
                    end
                end
                ST_RESP: begin
                    cnt <= cnt_next;
                    if (MEM_RVALID) begin
                        RDATA <= a_load;
                        DONE  <= 1'b1;
                        state <= ST_FIN;
                    end else if (cnt == CNT_LAST) begin
                        RDATA <= '0;
                        ERR   <= 1'b1;
                        DONE  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // Rejected accesses arrive here with DONE low and spend one
                    // extra cycle raising it, keeping their latency at two cycles.
                    if (DONE) begin
                        DONE          <= 1'b0;
                        BUSY          <= 1'b0;
                        MISALIGN      <= 1'b0;
                        ERR           <= 1'b0;
                        pend_misalign <= 1'b0;
                        pend_err      <= 1'b0;
                        state         <= ST_IDLE;
                    end else begin
                        DONE     <= 1'b1;
                        MISALIGN <= pend_misalign;
                        ERR      <= pend_err;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: randomized and directed accesses, a bus
// responder with programmable grant/valid delays, and a DONE monitor.
module tb_core_lsu;

    localparam int TO = 4;

    localparam logic [7:0] OP_LB  = 8'b1000_0000;
    localparam logic [7:0] OP_LH  = 8'b0100_0000;
    localparam logic [7:0] OP_LW  = 8'b0010_0000;
    localparam logic [7:0] OP_LBU = 8'b0001_0000;
    localparam logic [7:0] OP_LHU = 8'b0000_1000;
    localparam logic [7:0] OP_SB  = 8'b0000_0100;
    localparam logic [7:0] OP_SH  = 8'b0000_0010;
    localparam logic [7:0] OP_SW  = 8'b0000_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  flags;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    core_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK        (clk),
        .RST        (rst),
        .START      (start),
        .I_LB       (flags[7]),
        .I_LH       (flags[6]),
        .I_LW       (flags[5]),
        .I_LBU      (flags[4]),
        .I_LHU      (flags[3]),
        .I_SB       (flags[2]),
        .I_SH       (flags[1]),
        .I_SW       (flags[0]),
        .ADDR       (addr),
        .WDATA      (wdata),
        .BUSY       (busy),
        .DONE       (done),
        .RDATA      (rdata),
        .MISALIGN   (misalign),
        .ERR        (err),
        .MEM_REQ    (mem_req),
        .MEM_WE     (mem_we),
        .MEM_ADDR   (mem_addr),
        .MEM_BE     (mem_be),
        .MEM_WDATA  (mem_wdata),
        .MEM_GNT    (mem_gnt),
        .MEM_RVALID (mem_rvalid),
        .MEM_RDATA  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    logic [31:0] last_rdata = '0;
    logic        exp_bus    = 1'b0;
    logic        exp_we     = 1'b0;
    logic [31:0] exp_maddr  = '0;
    logic [3:0]  exp_be     = '0;
    logic [31:0] exp_mwdata = '0;
    logic [31:0] mem_word   = '0;
    int          gnt_d      = 0;
    int          rv_d       = 0;
    logic        resp_busy  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(busy),      32'd0);
        check({tag, "_done"},     32'(done),      32'd0);
        check({tag, "_rdata"},    rdata,          32'd0);
        check({tag, "_misalign"}, 32'(misalign),  32'd0);
        check({tag, "_err"},      32'(err),       32'd0);
        check({tag, "_mem_req"},  32'(mem_req),   32'd0);
        check({tag, "_mem_we"},   32'(mem_we),    32'd0);
        check({tag, "_mem_addr"}, mem_addr,       32'd0);
        check({tag, "_mem_be"},   32'(mem_be),    32'd0);
        check({tag, "_mem_wd"},   mem_wdata,      32'd0);
    endtask

    // Reference model: access width and signedness straight from the op table.
    function automatic int op_bytes(input logic [7:0] f);
        if ((f & (OP_LB | OP_LBU | OP_SB)) != 0) return 1;
        if ((f & (OP_LH | OP_LHU | OP_SH)) != 0) return 2;
        return 4;
    endfunction

    task automatic apply_stimulus(input logic [7:0] f, input logic [31:0] a, input logic [31:0] wd,
                                  input int gd, input int rd, input logic [31:0] mw);
        exp_t        e;
        int          nb;
        int          o;
        int          needed;
        logic        is_store;
        logic        is_signed;
        logic [31:0] s;
        logic [31:0] mask;
        nb        = op_bytes(f);
        o         = int'(a[1:0]);
        is_store  = (f & (OP_SB | OP_SH | OP_SW)) != 0;
        is_signed = (f & (OP_LB | OP_LH)) != 0;
        exp_bus   = 1'b0;
        e.mis     = 1'b0;
        e.err     = 1'b0;
        if ($countones(f) != 1) begin
            e.err      = 1'b1;
            e.done_cyc = cyc + 2;
        end else if ((o % nb) != 0) begin
            e.mis      = 1'b1;
            e.done_cyc = cyc + 2;
        end else begin
            exp_bus   = 1'b1;
            exp_we    = is_store;
            exp_maddr = a & 32'hFFFF_FFFC;
            for (int i = 0; i < 4; i++) begin
                exp_be[i]           = (i >= o) && (i < o + nb);
                exp_mwdata[8*i +: 8] = wd[8*(i % nb) +: 8];
            end
            needed = is_store ? gd + 1 : gd + rd + 2;
            if (needed > TO) begin
                e.err      = 1'b1;
                last_rdata = '0;
                e.done_cyc = cyc + 1 + TO;
            end else begin
                if (!is_store) begin
                    s    = mw >> (8 * o);
                    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
                    s    = s & mask;
                    if (is_signed && s[8*nb-1]) s = s | ~mask;
                    last_rdata = s;
                end
                e.done_cyc = cyc + 1 + needed;
            end
        end
        e.rdata  = last_rdata;
        sb.push_back(e);
        gnt_d    = gd;
        rv_d     = rd;
        mem_word = mw;
        start    = 1'b1;
        flags    = f;
        addr     = a;
        wdata    = wd;
        @(negedge clk);
        start    = 1'b0;
        flags    = '0;
        addr     = $urandom;
        wdata    = $urandom;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0 && !resp_busy) return;
        end
        check({name, "_idle_timeout"}, 32'd1, 32'd0);
        sb.delete();
    endtask

    // Memory responder: grants after gnt_d REQ cycles, returns data rv_d cycles later.
    initial begin : responder
        int   phase;
        int   k;
        logic granted;
        phase      = 0;
        k          = 0;
        granted    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (phase == 0 && mem_req === 1'b1) begin
                if (!exp_bus) begin
                    check("unexpected_mem_req", 32'(mem_req), 32'd0);
                end else begin
                    phase     = 1;
                    k         = 0;
                    granted   = 1'b0;
                    resp_busy = 1'b1;
                end
            end else if (phase == 1 && mem_req !== 1'b1) begin
                if (granted && !exp_we) begin
                    phase = 2;
                    k     = 0;
                end else begin
                    phase     = 0;
                    resp_busy = 1'b0;
                end
                granted = 1'b0;
            end
            if (phase == 1 && mem_req === 1'b1) begin
                check("req_we",    32'(mem_we), 32'(exp_we));
                check("req_addr",  mem_addr,    exp_maddr);
                check("req_be",    32'(mem_be), 32'(exp_be));
                check("req_wdata", mem_wdata,   exp_mwdata);
                mem_gnt = (k == gnt_d);
                granted = mem_gnt;
                k++;
            end else if (phase == 2) begin
                if (k == rv_d) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word;
                    phase      = 0;
                    resp_busy  = 1'b0;
                end else begin
                    mem_rdata = $urandom;
                end
                k++;
            end
        end
    end

    // Completion monitor: every DONE pops one expected result.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_rdata",    rdata,          e.rdata);
                    check("done_misalign", 32'(misalign),  32'(e.mis));
                    check("done_err",      32'(err),       32'(e.err));
                    check("done_busy",     32'(busy),      32'd1);
                    check("done_cycle",    32'(cyc),       32'(e.done_cyc));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic random_access();
        logic [7:0] f;
        int         r;
        int         a0;
        int         a1;
        int         gd;
        int         rd;
        r = $urandom_range(0, 9);
        if (r < 8) begin
            f = 8'(1 << r);
        end else if (r == 8) begin
            f = '0;
        end else begin
            a0 = $urandom_range(0, 7);
            a1 = (a0 + $urandom_range(1, 7)) % 8;
            f  = 8'((1 << a0) | (1 << a1));
        end
        if ($urandom_range(0, 7) == 0) gd = TO;
        else if ((f & (OP_SB | OP_SH | OP_SW)) != 0) gd = $urandom_range(0, TO - 1);
        else gd = $urandom_range(0, TO - 2);
        rd = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
        apply_stimulus(f, $urandom, $urandom, gd, rd, $urandom);
        wait_idle("random");
    endtask

    initial begin : stimulus
        rst   = 1'b1;
        start = 1'b0;
        flags = '0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        apply_stimulus(OP_SW, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 32'h0);
        wait_idle("sw_basic");
        apply_stimulus(OP_SB, 32'h0000_0103, 32'h1234_5678, 3, 0, 32'h0);
        wait_idle("sb_wait");
        apply_stimulus(OP_LB, 32'h0000_0202, 32'h0, 0, 0, 32'h0080_0000);
        wait_idle("lb");
        apply_stimulus(OP_LBU, 32'h0000_0202, 32'h0, 1, 1, 32'h0080_0000);
        wait_idle("lbu");
        apply_stimulus(OP_LHU, 32'h0000_0202, 32'h0, 0, 2, 32'hBEEF_0000);
        wait_idle("lhu");
        apply_stimulus(OP_LW, 32'h0000_0301, 32'h0, 0, 0, 32'h0);
        wait_idle("lw_mis");
        apply_stimulus(OP_SH, 32'h0000_0305, 32'h0, 0, 0, 32'h0);
        wait_idle("sh_mis");

        // A START while busy must neither complete nor reach the bus.
        apply_stimulus(OP_SW, 32'h0000_0500, 32'hCAFE_F00D, 2, 0, 32'h0);
        start = 1'b1;
        flags = OP_SB;
        addr  = 32'h0000_0999;
        @(negedge clk);
        start = 1'b0;
        flags = '0;
        wait_idle("start_busy");

        apply_stimulus(8'h00, 32'h0000_0600, 32'h0, 0, 0, 32'h0);
        wait_idle("no_op");
        apply_stimulus(OP_LW | OP_SW, 32'h0000_0600, 32'h0, 0, 0, 32'h0);
        wait_idle("two_ops");

        apply_stimulus(OP_LW, 32'h0000_0700, 32'h0, 0, 3, 32'h1111_2222);
        wait_idle("lw_timeout");
        check("timeout_rdata_after", rdata, 32'd0);
        check("timeout_busy_after", 32'(busy), 32'd0);
        apply_stimulus(OP_LH, 32'h0000_0702, 32'h0, 0, 2, 32'h8001_0000);
        wait_idle("lh_edge");
        apply_stimulus(OP_SW, 32'h0000_0704, 32'h5555_AAAA, TO, 0, 32'h0);
        wait_idle("sw_timeout");

        apply_stimulus(OP_LW, 32'h0000_0800, 32'h0, 0, 3, 32'h3333_4444);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        sb.delete();
        last_rdata = '0;
        wait_idle("post_reset");
        apply_stimulus(OP_SW, 32'h0000_0900, 32'h0BAD_CAFE, 1, 0, 32'h0);
        wait_idle("sw_after_reset");

        for (int n = 0; n < 200; n++) random_access();

        check("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
